// File: rtl/ser_pkg.sv
// Shared types and defaults for serial_byte_sender.
// The optional holding buffer is selected with SER_HOLDBUF_EN.
package ser_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      GAP
   } ser_state_t;

   localparam int unsigned SER_DATA_W     = 8;
   localparam int unsigned SER_GAP_CYCLES = 1;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((32'd1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/serial_byte_sender_if.sv
// Producer-to-sender byte handshake plus the serial outputs toward the SIPO register.
// master = producer side, slave = serial_byte_sender.
interface serial_byte_sender_if
   import ser_pkg::*;
#(
   parameter int unsigned DATA_W = SER_DATA_W
);
   logic [DATA_W-1:0] byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              ser_out;
   logic              shift_en;
   logic              frame_done;

   modport master (
      output byte_in, byte_valid,
      input  byte_ready, ser_out, shift_en, frame_done
   );

   modport slave (
      input  byte_in, byte_valid,
      output byte_ready, ser_out, shift_en, frame_done
   );
endinterface

// File: rtl/ser_hold_buf.sv
// One-entry valid/ready holding register for serial_byte_sender.
// Only instantiated when SER_HOLDBUF_EN is defined.
module ser_hold_buf
   import ser_pkg::*;
#(
   parameter int unsigned DATA_W = SER_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] push_data,
   input  logic              push_valid,
   output logic              push_ready,
   output logic [DATA_W-1:0] pop_data,
   output logic              pop_valid,
   input  logic              pop_ready
);
   logic              full;
   logic [DATA_W-1:0] data;

   always_ff @(posedge clk) begin
      if (rst) begin
         full <= 1'b0;
         data <= '0;
      end else if (push_valid && push_ready) begin
         full <= 1'b1;
         data <= push_data;
      end else if (pop_valid && pop_ready) begin
         full <= 1'b0;
      end
   end

   assign push_ready = !full;
   assign pop_valid  = full;
   assign pop_data   = data;
endmodule

// File: rtl/serial_byte_sender.sv
// Parallel byte in, LSB-first serial out with shift_en qualifier and frame gap.
// Define SER_HOLDBUF_EN to add a one-entry buffer for back-to-back frames.
module serial_byte_sender
   import ser_pkg::*;
#(
   parameter int unsigned DATA_W     = SER_DATA_W,
   parameter int unsigned GAP_CYCLES = SER_GAP_CYCLES
) (
   input logic                 clk,
   input logic                 rst,
   serial_byte_sender_if.slave bus
);
   localparam int unsigned      CNT_W    = cnt_width(DATA_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
   localparam logic [3:0]       GAP_LAST = 4'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

   ser_state_t        state, state_nxt;
   logic [DATA_W-1:0] sreg, sreg_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic [3:0]        gap_cnt, gap_cnt_nxt;
   logic              done, done_nxt;
   logic              ready, accept, frame_end, load_pt, src_valid;
   logic [DATA_W-1:0] src_data;

   // Last cycle of frame plus gap: the point where a waiting byte may reload.
   assign frame_end = (GAP_CYCLES == 0) ? (state == SHIFT && cnt == CNT_LAST)
                                        : (state == GAP && gap_cnt == GAP_LAST);
   assign accept    = bus.byte_valid && ready;

`ifdef SER_HOLDBUF_EN
   logic              buf_valid, buf_empty, buf_push, buf_pop;
   logic [DATA_W-1:0] buf_data;

   assign load_pt   = (state == IDLE) || frame_end;
   assign ready     = !rst && buf_empty;
   // A byte arriving at a load point with the buffer empty goes straight to sreg.
   assign buf_push  = bus.byte_valid && !rst && !(load_pt && !buf_valid);
   assign buf_pop   = load_pt && buf_valid;
   assign src_valid = buf_valid || accept;
   assign src_data  = buf_valid ? buf_data : bus.byte_in;

   ser_hold_buf #(.DATA_W(DATA_W)) u_hold (
      .clk       (clk),
      .rst       (rst),
      .push_data (bus.byte_in),
      .push_valid(buf_push),
      .push_ready(buf_empty),
      .pop_data  (buf_data),
      .pop_valid (buf_valid),
      .pop_ready (buf_pop)
   );
`else
   assign load_pt   = (state == IDLE);
   assign ready     = !rst && (state == IDLE);
   assign src_valid = accept;
   assign src_data  = bus.byte_in;
`endif

   always_comb begin
      state_nxt   = state;
      sreg_nxt    = sreg;
      cnt_nxt     = cnt;
      gap_cnt_nxt = gap_cnt;
      done_nxt    = 1'b0;
      unique case (state)
         IDLE: ;
         SHIFT: begin
            sreg_nxt = sreg >> 1;
            cnt_nxt  = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
               done_nxt    = 1'b1;
               cnt_nxt     = '0;
               gap_cnt_nxt = '0;
               state_nxt   = (GAP_CYCLES == 0) ? IDLE : GAP;
            end
         end
         GAP: begin
            gap_cnt_nxt = gap_cnt + 1'b1;
            if (gap_cnt == GAP_LAST) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (load_pt && src_valid) begin
         state_nxt = SHIFT;
         sreg_nxt  = src_data;
         cnt_nxt   = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         sreg    <= '0;
         cnt     <= '0;
         gap_cnt <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_nxt;
         sreg    <= sreg_nxt;
         cnt     <= cnt_nxt;
         gap_cnt <= gap_cnt_nxt;
         done    <= done_nxt;
      end
   end

   assign bus.byte_ready = ready;
   assign bus.shift_en   = !rst && (state == SHIFT);
   assign bus.ser_out    = !rst && (state == SHIFT) && sreg[0];
   assign bus.frame_done = !rst && done;
endmodule

// File: tb/tb_serial_byte_sender.sv
// Bench for serial_byte_sender: per-cycle frame-schedule model, vector table, corner sequences.
// Expectations follow SER_HOLDBUF_EN when it is defined for the build.
module tb_serial_byte_sender;
   import ser_pkg::*;

   localparam int unsigned D = SER_DATA_W;
   localparam int unsigned G = 1;
`ifdef SER_HOLDBUF_EN
   localparam bit HB = 1'b1;
`else
   localparam bit HB = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   serial_byte_sender_if #(.DATA_W(D)) bus1 ();
   serial_byte_sender_if #(.DATA_W(D)) bus0 ();

   serial_byte_sender #(.DATA_W(D), .GAP_CYCLES(G)) dut (.clk(clk), .rst(rst), .bus(bus1));
   serial_byte_sender #(.DATA_W(D), .GAP_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk1(input string name, input logic got, input logic want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s cycle %0d: got %b want %b", name, cyc, got, want);
      end
   endfunction

   function automatic void chkn(input string name, input int got, input int want);
      tests++;
      if (got != want) begin
         fails++;
         $display("FAIL %s cycle %0d: got %0d want %0d", name, cyc, got, want);
      end
   endfunction

   // Downstream SIPO register: serial-in at the top, LSB ends in bit 0.
   logic [D-1:0] po = '0;
   always @(posedge clk) if (bus1.shift_en === 1'b1) po <= {bus1.ser_out, po[D-1:1]};

   // Reference model: list of scheduled frames (start cycle of bit0, byte).
   typedef struct {
      int           start;
      logic [D-1:0] data;
   } frame_t;
   frame_t frames[$];
   int     accepts = 0;
   int     fd_seen = 0;

   function automatic bit model_ready(input int c);
      if (rst) return 1'b0;
      if (HB) begin
         foreach (frames[i]) if (frames[i].start > c) return 1'b0;
         return 1'b1;
      end
      if (frames.size() == 0) return 1'b1;
      return c >= frames[frames.size()-1].start + int'(D) + int'(G);
   endfunction

   logic         e_en, e_ser, e_fd, e_rdy;
   logic [D-1:0] fd_data;
   frame_t       nf;
   always @(negedge clk) begin
      e_en = 1'b0; e_ser = 1'b0; e_fd = 1'b0; fd_data = '0;
      e_rdy = model_ready(cyc);
      if (!rst) foreach (frames[i]) begin
         if (cyc >= frames[i].start && cyc < frames[i].start + int'(D)) begin
            e_en  = 1'b1;
            e_ser = frames[i].data[cyc - frames[i].start];
         end
         if (cyc == frames[i].start + int'(D)) begin
            e_fd    = 1'b1;
            fd_data = frames[i].data;
         end
      end
      chk1("byte_ready", bus1.byte_ready, e_rdy);
      chk1("shift_en", bus1.shift_en, e_en);
      chk1("ser_out", bus1.ser_out, e_ser);
      chk1("frame_done", bus1.frame_done, e_fd);
      if (e_fd) chkn("po", int'(po), int'(fd_data));
      if (bus1.frame_done === 1'b1) fd_seen++;
      if (rst) frames.delete();
      else if (bus1.byte_valid && e_rdy) begin
         nf.start = cyc + 1;
         if (HB && frames.size() > 0 &&
             frames[frames.size()-1].start + int'(D) + int'(G) > nf.start)
            nf.start = frames[frames.size()-1].start + int'(D) + int'(G);
         nf.data = bus1.byte_in;
         frames.push_back(nf);
         accepts++;
      end
      while (frames.size() > 1 && frames[0].start + int'(D) < cyc) void'(frames.pop_front());
   end

   // Hold byte_valid until accepted; n is the cycle whose closing edge took it.
   task automatic send(input logic [D-1:0] d, output int n);
      bit got;
      got = 1'b0;
      n = -1000;
      bus1.byte_in = d;
      bus1.byte_valid = 1'b1;
      for (int i = 0; i < 64 && !got; i++) begin
         @(negedge clk);
         if (bus1.byte_ready === 1'b1) begin got = 1'b1; n = cyc; end
         @(posedge clk); #1;
      end
      bus1.byte_valid = 1'b0;
      if (!got) chk1("accept_timeout", 1'b0, 1'b1);
   endtask

   task automatic send_collect(input logic [D-1:0] d, output logic [D-1:0] bits,
                               output int en_cnt, output int fd_off);
      int n;
      send(d, n);
      bits = '0; en_cnt = 0; fd_off = -1;
      for (int i = 0; i <= int'(D) + 1; i++) begin
         @(negedge clk);
         if (bus1.shift_en === 1'b1) begin
            en_cnt++;
            if (i < int'(D)) bits[3'(i)] = bus1.ser_out;
         end
         if (bus1.frame_done === 1'b1 && fd_off < 0) fd_off = cyc - n;
      end
      @(posedge clk); #1;
   endtask

   typedef struct {
      logic [D-1:0] data;
      logic [D-1:0] exp_bits;
      int           exp_en;
      int           exp_fd_off;
   } vec_t;
   vec_t vecs[6];

   initial begin
      #200000;
      $display("FAIL global_timeout cycle %0d", cyc);
      $fatal(1, "timeout");
   end

   logic [D-1:0] bits;
   logic [D-1:0] bytes0 [3];
   int en_cnt, fd_off, n, m, s2, f0, a0, cnt, first, idx, fd_n, en_tot, run, maxrun;
   int fdc [3];
   bit acc;

   initial begin
      vecs[0] = '{8'hA5, 8'hA5, 8, 9};
      vecs[1] = '{8'h3C, 8'h3C, 8, 9};
      vecs[2] = '{8'h00, 8'h00, 8, 9};
      vecs[3] = '{8'hFF, 8'hFF, 8, 9};
      vecs[4] = '{8'h01, 8'h01, 8, 9};
      vecs[5] = '{8'h80, 8'h80, 8, 9};
      bus1.byte_in = '0; bus1.byte_valid = 1'b0;
      bus0.byte_in = '0; bus0.byte_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      foreach (vecs[i]) begin
         send_collect(vecs[i].data, bits, en_cnt, fd_off);
         chkn("vec_bits", int'(bits), int'(vecs[i].exp_bits));
         chkn("vec_en_cycles", en_cnt, vecs[i].exp_en);
         chkn("vec_fd_offset", fd_off, vecs[i].exp_fd_off);
      end

      // byte_valid held across two bytes
      bus1.byte_in = 8'h3C; bus1.byte_valid = 1'b1;
      n = -1000;
      for (int i = 0; i < 32 && n < 0; i++) begin
         @(negedge clk);
         if (bus1.byte_ready === 1'b1) n = cyc;
         @(posedge clk); #1;
      end
      bus1.byte_in = 8'hC3;
      m = -1000; s2 = -1000;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (m < 0 && bus1.byte_ready === 1'b1) m = cyc;
         if (s2 < 0 && cyc > n + int'(D) && bus1.shift_en === 1'b1) s2 = cyc;
         @(posedge clk); #1;
         if (m >= 0) bus1.byte_valid = 1'b0;
      end
      chkn("held_accept_spacing", m - n, HB ? 1 : 10);
      chkn("held_second_start", s2 - n, HB ? 10 : 11);

      // reset in cycle 4 of an 8'hFF frame
      f0 = fd_seen;
      send(8'hFF, n);
      while (cyc < n + 4) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      @(negedge clk);
      chk1("rst_mid_shift_en", bus1.shift_en, 1'b0);
      chk1("rst_mid_ser_out", bus1.ser_out, 1'b0);
      chk1("rst_mid_ready", bus1.byte_ready, 1'b1);
      repeat (12) @(negedge clk);
      chkn("rst_mid_no_done", fd_seen - f0, 0);
      @(posedge clk); #1;
      send_collect(8'h01, bits, en_cnt, fd_off);
      chkn("post_rst_bits", int'(bits), 8'h01);
      chkn("post_rst_fd_offset", fd_off, 9);

      // reset together with byte_valid
      rst = 1'b1; bus1.byte_in = 8'h5A; bus1.byte_valid = 1'b1;
      @(negedge clk);
      chk1("rst_valid_ready", bus1.byte_ready, 1'b0);
      chk1("rst_valid_shift_en", bus1.shift_en, 1'b0);
      @(posedge clk); #1 rst = 1'b0; bus1.byte_valid = 1'b0;
      @(negedge clk);
      chk1("rst_release_ready", bus1.byte_ready, 1'b1);
      chk1("rst_release_no_accept", bus1.shift_en, 1'b0);
      @(posedge clk); #1;

      // byte_valid toggling during a frame
      f0 = fd_seen; a0 = accepts;
      send(8'h5A, n);
      for (int i = 0; i < 40; i++) begin
         bus1.byte_valid = 1'($urandom_range(0, 1));
         bus1.byte_in = 8'($urandom);
         @(posedge clk); #1;
      end
      bus1.byte_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chkn("done_per_accept", fd_seen - f0, accepts - a0);

      // randomized traffic with occasional reset
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 49) == 0);
         bus1.byte_valid = ($urandom_range(0, 9) < 6);
         bus1.byte_in = 8'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b0; bus1.byte_valid = 1'b0;
      repeat (30) @(posedge clk);
      #1;

      // zero-gap streaming of 00, FF, 81
      bytes0[0] = 8'h00; bytes0[1] = 8'hFF; bytes0[2] = 8'h81;
      idx = 0; first = -1; fd_n = 0; en_tot = 0; run = 0; maxrun = 0;
      fdc[0] = -1; fdc[1] = -1; fdc[2] = -1;
      bus0.byte_in = bytes0[0]; bus0.byte_valid = 1'b1;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (bus0.shift_en === 1'b1) begin
            en_tot++; run++;
            if (run > maxrun) maxrun = run;
         end else run = 0;
         acc = bus0.byte_valid && (bus0.byte_ready === 1'b1);
         if (acc && first < 0) first = cyc;
         if (bus0.frame_done === 1'b1 && fd_n < 3) begin fdc[fd_n] = cyc - first; fd_n++; end
         @(posedge clk); #1;
         if (acc) begin
            idx++;
            if (idx < 3) bus0.byte_in = bytes0[idx];
            else bus0.byte_valid = 1'b0;
         end
      end
      chkn("gap0_done_count", fd_n, 3);
      chkn("gap0_done0", fdc[0], 9);
      chkn("gap0_done1", fdc[1], HB ? 17 : 18);
      chkn("gap0_done2", fdc[2], HB ? 25 : 27);
      chkn("gap0_shift_total", en_tot, 24);
      chkn("gap0_shift_run", maxrun, HB ? 24 : 8);

      cnt = tests;
      $display("[TB] %0d tests run, %0d failed", cnt, fails);
      $finish;
   end
endmodule
